shift_lui_unit: RTL and testbench

//  Parametrised multi-cycle shift/LUI execution unit for the MIPS32 datapath; generalises the fixed 32-bit LUI wiring.

---
 rtl/shift_pkg.sv | 26 ++
 rtl/shift_step.sv | 40 ++++
 rtl/shift_lui_unit.sv | 105 ++++++++++
 tb/tb_shift_lui_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift/LUI execution unit: op encodings, FSM states
// and small op-classification helpers.
package shift_pkg;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_ROTR = 3'b011;
  localparam logic [2:0] OP_LUI  = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_LUI;
  endfunction

  // Only the four shift ops iterate; LUI and illegal ops finish in one pass.
  function automatic logic op_iterates(input logic [2:0] op);
    return op < OP_LUI;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step of the iterative shifter: applies op to data by k
// bits, where k ranges over 0..STEP. Non-shift ops pass data through.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] res
);

  logic signed [WIDTH-1:0] sdata;
  logic [WIDTH-1:0]        cand [STEP+1];

  assign sdata = data;

  // One candidate per possible step size; k then picks among them.
  for (genvar gi = 0; gi <= STEP; gi++) begin : g_amt
    logic [WIDTH-1:0] sra_v;
    logic [WIDTH-1:0] rotr_v;
    assign sra_v  = sdata >>> gi;
    assign rotr_v = (data >> gi) | (data << (WIDTH - gi));
    assign cand[gi] = (op == OP_SLL)  ? (data << gi) :
                      (op == OP_SRL)  ? (data >> gi) :
                      (op == OP_SRA)  ? sra_v        :
                      (op == OP_ROTR) ? rotr_v       : data;
  end

  always_comb begin
    res = data;
    for (int i = 0; i <= STEP; i++) begin
      if (k == KW'(i)) res = cand[i];
    end
  end

endmodule

// File: rtl/shift_lui_unit.sv
// Multi-cycle shift/LUI unit: iterates SLL/SRL/SRA/ROTR up to STEP bits per
// cycle, does LUI in one pass, valid/ready on both request and result sides.
module shift_lui_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int KW = $clog2(STEP + 1);

  state_t           state_reg, state_next;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] data_reg;
  logic [SHW-1:0]   rem_reg;
  logic             err_reg;

  logic [KW-1:0]    k;
  logic [WIDTH-1:0] step_data;
  logic             accept;
  logic             direct_done;

  assign accept      = in_valid && in_ready;
  assign direct_done = !op_iterates(in_op) || (in_shamt == '0);

  always_comb begin
    if (int'(rem_reg) < STEP) k = KW'(rem_reg);
    else                      k = KW'(STEP);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .op   (op_reg),
    .data (data_reg),
    .k    (k),
    .res  (step_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = direct_done ? S_DONE : S_SHIFT;
      // k never exceeds rem, so rem==k means this is the final step.
      S_SHIFT: if (rem_reg == SHW'(k)) state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == S_IDLE);
    out_valid = (state_reg == S_DONE);
    out_data  = out_valid ? data_reg : '0;
    out_err   = out_valid && err_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg   <= OP_SLL;
      data_reg <= '0;
      rem_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg   <= in_op;
            rem_reg  <= in_shamt;
            err_reg  <= !op_legal(in_op);
            data_reg <= (in_op == OP_LUI)
                        ? {in_data[WIDTH/2-1:0], {(WIDTH/2){1'b0}}}
                        : in_data;
          end
        end
        S_SHIFT: begin
          data_reg <= step_data;
          rem_reg  <= rem_reg - SHW'(k);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_lui_unit.sv
// Randomized and directed bench for shift_lui_unit against a whole-word
// reference model of each op and of the expected result latency.
module tb_shift_lui_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'b000;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  shift_lui_unit #(.WIDTH(32), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result: {err, data}, computed bit-by-bit from the op definitions.
  function automatic logic [32:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input int s);
    logic [31:0] r;
    r = a;
    case (op)
      3'd0: r = a << s;
      3'd1: r = a >> s;
      3'd2: for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? a[i+s] : a[31];
      3'd3: for (int i = 0; i < 32; i++) r[i] = a[(i + s) % 32];
      3'd4: r = {a[15:0], 16'h0000};
      default: return {1'b1, a};
    endcase
    return {1'b0, r};
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input int s);
    if (op >= 3'd4 || s == 0) return 1;
    return 1 + (s + 3) / 4;
  endfunction

  // Issues one request and collects its result; hold = cycles of back-pressure.
  task automatic run_op(input logic [2:0] op, input logic [31:0] d, input logic [4:0] s,
                        input int hold);
    logic [32:0] exp;
    int          lat;
    int          elat;
    exp  = ref_result(op, d, int'(s));
    elat = ref_latency(op, int'(s));
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = d;
    in_shamt  = s;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("out_data", out_data, exp[31:0]);
    chk("out_err", 32'(out_err), 32'(exp[32]));
    $display("[TB] op=%0d data=%h shamt=%0d -> data=%h err=%0d lat=%0d hold=%0d",
             op, d, s, out_data, out_err, lat, hold);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, exp[31:0]);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen_valid;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;

    run_op(3'd0, 32'h0000_0001, 5'd31, 0);
    run_op(3'd2, 32'h8000_00F0, 5'd4, 0);
    run_op(3'd1, 32'h8000_00F0, 5'd4, 0);
    run_op(3'd3, 32'h1234_5678, 5'd8, 0);
    run_op(3'd4, 32'hDEAD_BEEF, 5'd13, 0);
    run_op(3'd7, 32'h1357_9BDF, 5'd9, 0);
    run_op(3'd2, 32'hF0F0_0000, 5'd17, 5);

    // Reset during SHIFT aborts the operation.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_data = 32'h0000_0001; in_shamt = 5'd31;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    seen_valid = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    chk("abort_no_result", 32'(seen_valid), 32'd0);
    run_op(3'd0, 32'h0000_00A5, 5'd0, 0);

    for (int t = 0; t < 150; t++) begin
      run_op(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
             int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
